// File: rtl/gate_tester_if.sv
// Gate-side link of the tester: the tester drives a/b and observes c.
// master = tester, slave = gate under test.
interface gate_tester_if;
    logic dut_a;
    logic dut_b;
    logic dut_c;

    modport master (output dut_a, output dut_b, input dut_c);
    modport slave  (input dut_a, input dut_b, output dut_c);
endinterface

// File: rtl/gate_tester.sv
// Walks the four {a,b} vectors into a 2-input gate and checks c against EXPECT.
// Latency: 4*(SETTLE+1) busy cycles, then a 1-cycle done pulse.
// Backpressure: start is only accepted in IDLE; it is ignored in WAIT and DONE.
module gate_tester #(
    parameter logic [3:0]  EXPECT = 4'b0001,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    gate_tester_if.master        gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           err_count,
    output logic [3:0]           fail_vec
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     state;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic       mismatch;
    logic [2:0] err_nxt;
    logic [3:0] fail_nxt;

    // Result of the sample taken this cycle, folded into the running tallies.
    always_comb begin
        mismatch = gate.dut_c != EXPECT[vec];
        err_nxt  = err_count + {2'b00, mismatch};
        fail_nxt = fail_vec;
        if (mismatch) fail_nxt[vec] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            cnt        <= 8'd0;
            gate.dut_a <= 1'b0;
            gate.dut_b <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= WAIT;
                        busy       <= 1'b1;
                        vec        <= 2'd0;
                        gate.dut_a <= 1'b0;
                        gate.dut_b <= 1'b0;
                        cnt        <= SETTLE_CNT;
                        err_count  <= 3'd0;
                        fail_vec   <= 4'd0;
                        pass       <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        err_count <= err_nxt;
                        fail_vec  <= fail_nxt;
                        if (vec == 2'd3) begin
                            // pass must include the final vector's verdict
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == 3'd0);
                        end else begin
                            vec        <= vec + 2'd1;
                            {gate.dut_a, gate.dut_b} <= vec + 2'd1;
                            cnt        <= SETTLE_CNT;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
